uio_cfg_decoder: RTL and testbench

- Consumes the synchronised HPS user-I/O word stream (io_uio, io_strobe, io_din) in the clk_sys domain and decodes the system-level UIO commands.
- Outputs are the system config word, the aspect-ratio pair and a readback path onto io_dout.
- Downstream consumers are the HDMI config, VGA and audio blocks, which use cfg, cfg_ready and cfg_upd.
- Replaces the inline command latch in the top level with a full state machine that handles multi-word commands and bad commands.

---
 rtl/uio_cfg_decoder_if.sv | 11 +
 rtl/uio_cfg_decoder.sv | 150 +++++++++++++++
 tb/tb_uio_cfg_decoder.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uio_cfg_decoder_if.sv
// HPS user-I/O word stream as seen in the clk_sys domain.
// master = HPS side, slave = uio_cfg_decoder.
interface uio_cfg_decoder_if;
  logic        io_uio;
  logic        io_strobe;
  logic [15:0] io_din;
  logic [15:0] io_dout;

  modport master (output io_uio, output io_strobe, output io_din, input io_dout);
  modport slave  (input io_uio, input io_strobe, input io_din, output io_dout);
endinterface

// File: rtl/uio_cfg_decoder.sv
// System-level UIO command decoder: cfg word, aspect ratio, error count and readback.
// Optional readback of status (cmd 0x03) is enabled by defining UIO_CFG_READBACK_EN.
//
// state | meaning
// IDLE  | no transaction, io_uio low
// CMD   | transaction open, waiting for the command word
// DATA  | known command, consuming data words
// SKIP  | unknown command, ignoring words until io_uio falls
module uio_cfg_decoder #(
  parameter logic [15:0] CFG_DEFAULT = 16'h0000,
  parameter logic [7:0]  ARX_DEFAULT = 8'd16,
  parameter logic [7:0]  ARY_DEFAULT = 8'd9,
  parameter logic [7:0]  VERSION     = 8'h01
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  uio_cfg_decoder_if.slave    uio,
  output logic [15:0]         cfg,
  output logic                cfg_ready,
  output logic                cfg_upd,
  output logic [7:0]          arx,
  output logic [7:0]          ary,
  output logic [7:0]          err_cnt
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, SKIP} state_t;

  localparam logic [7:0] CMD_CFG    = 8'h01;
  localparam logic [7:0] CMD_ASPECT = 8'h02;
  localparam logic [7:0] CMD_READ   = 8'h03;

  state_t      state, state_nxt;
  logic        old_strobe;
  logic        stb_edge;
  logic [7:0]  cmd, cmd_nxt;
  logic [2:0]  widx, widx_nxt;
  logic [15:0] cfg_nxt;
  logic        cfg_ready_nxt, cfg_upd_nxt;
  logic [7:0]  arx_nxt, ary_nxt, err_cnt_nxt;
  logic [15:0] dout_q, dout_nxt;

  assign stb_edge    = uio.io_strobe & ~old_strobe;
  assign uio.io_dout = dout_q;

  function automatic logic cmd_known(input logic [7:0] c);
`ifdef UIO_CFG_READBACK_EN
    return (c == CMD_CFG) || (c == CMD_ASPECT) || (c == CMD_READ);
`else
    return (c == CMD_CFG) || (c == CMD_ASPECT);
`endif
  endfunction

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      old_strobe <= 1'b0;
      cmd        <= 8'h00;
      widx       <= 3'd0;
      cfg        <= CFG_DEFAULT;
      cfg_ready  <= 1'b0;
      cfg_upd    <= 1'b0;
      arx        <= ARX_DEFAULT;
      ary        <= ARY_DEFAULT;
      err_cnt    <= 8'h00;
      dout_q     <= 16'h0000;
    end else begin
      state      <= state_nxt;
      old_strobe <= uio.io_strobe;
      cmd        <= cmd_nxt;
      widx       <= widx_nxt;
      cfg        <= cfg_nxt;
      cfg_ready  <= cfg_ready_nxt;
      cfg_upd    <= cfg_upd_nxt;
      arx        <= arx_nxt;
      ary        <= ary_nxt;
      err_cnt    <= err_cnt_nxt;
      dout_q     <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cmd_nxt       = cmd;
    widx_nxt      = widx;
    cfg_nxt       = cfg;
    cfg_ready_nxt = cfg_ready;
    cfg_upd_nxt   = 1'b0;
    arx_nxt       = arx;
    ary_nxt       = ary;
    err_cnt_nxt   = err_cnt;
    dout_nxt      = 16'h0000;

    // A falling io_uio wins over a coincident strobe edge.
    if (!uio.io_uio) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: state_nxt = CMD;
        CMD: begin
          if (stb_edge) begin
            cmd_nxt  = uio.io_din[7:0];
            widx_nxt = 3'd0;
            if (cmd_known(uio.io_din[7:0])) begin
              state_nxt = DATA;
            end else begin
              state_nxt = SKIP;
              if (err_cnt != 8'hFF) err_cnt_nxt = err_cnt + 8'd1;
            end
          end
        end
        DATA: begin
          if (stb_edge) begin
            if (widx == 3'd0) begin
              if (cmd == CMD_CFG) begin
                cfg_nxt       = uio.io_din;
                cfg_upd_nxt   = 1'b1;
                cfg_ready_nxt = 1'b1;
              end else if (cmd == CMD_ASPECT &&
                           uio.io_din[7:0] != 8'h00 && uio.io_din[15:8] != 8'h00) begin
                arx_nxt = uio.io_din[7:0];
                ary_nxt = uio.io_din[15:8];
              end
            end
            if (widx != 3'd7) widx_nxt = widx + 3'd1;
          end
        end
        SKIP: state_nxt = SKIP;
        default: state_nxt = IDLE;
      endcase
    end

`ifdef UIO_CFG_READBACK_EN
    if (state_nxt == DATA && cmd_nxt == CMD_READ) begin
      if (state == CMD) begin
        dout_nxt = {VERSION, 8'hA4};
      end else if (stb_edge) begin
        case (widx)
          3'd0:    dout_nxt = cfg;
          3'd1:    dout_nxt = {ary, arx};
          3'd2:    dout_nxt = {8'h00, err_cnt};
          default: dout_nxt = 16'h0000;
        endcase
      end else begin
        dout_nxt = dout_q;
      end
    end
`endif
  end

endmodule

// File: tb/tb_uio_cfg_decoder.sv
// Self-checking bench for uio_cfg_decoder: table-driven transactions plus corner sequences.
module tb_uio_cfg_decoder;
  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] cfg;
  logic        cfg_ready, cfg_upd;
  logic [7:0]  arx, ary, err_cnt;

  int checks = 0;
  int errors = 0;
  int upd_total = 0;

  uio_cfg_decoder_if u ();

  uio_cfg_decoder dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .uio       (u),
    .cfg       (cfg),
    .cfg_ready (cfg_ready),
    .cfg_upd   (cfg_upd),
    .arx       (arx),
    .ary       (ary),
    .err_cnt   (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) if (cfg_upd === 1'b1) upd_total++;

  typedef struct {
    logic [7:0]  cmd;
    logic [15:0] w0;
    logic [15:0] w1;
    int          n;
    logic [15:0] e_cfg;
    logic [7:0]  e_arx;
    logic [7:0]  e_ary;
    logic        e_ready;
    logic [7:0]  e_err;
    int          e_upd;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [15:0] w, output logic [15:0] d);
    @(negedge clk_sys);
    u.io_din    = w;
    u.io_strobe = 1'b1;
    @(negedge clk_sys);
    d           = u.io_dout;
    u.io_strobe = 1'b0;
  endtask

  task automatic xact(input logic [7:0] c, input logic [15:0] w0, input logic [15:0] w1,
                      input int n);
    logic [15:0] d;
    @(negedge clk_sys);
    u.io_uio = 1'b1;
    send_word({8'h00, c}, d);
    for (int i = 0; i < n; i++) send_word((i == 0) ? w0 : w1, d);
    @(negedge clk_sys);
    u.io_uio = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic chk_all(input string tag, input logic [15:0] e_cfg, input logic [7:0] e_arx,
                         input logic [7:0] e_ary, input logic e_ready, input logic [7:0] e_err);
    chk({tag, ".cfg"}, cfg, e_cfg);
    chk({tag, ".arx"}, {8'h00, arx}, {8'h00, e_arx});
    chk({tag, ".ary"}, {8'h00, ary}, {8'h00, e_ary});
    chk({tag, ".cfg_ready"}, {15'h0, cfg_ready}, {15'h0, e_ready});
    chk({tag, ".err_cnt"}, {8'h00, err_cnt}, {8'h00, e_err});
  endtask

  initial begin
    int          upd0;
    logic [15:0] d;
    logic [15:0] rb[5];
    logic [15:0] rb_exp[5];
    logic [7:0]  e_err;

    vecs[0] = '{8'h01, 16'h0064, 16'h0000, 1, 16'h0064, 8'd16, 8'd9, 1'b1, 8'd0, 1};
    vecs[1] = '{8'h02, 16'h0304, 16'h0000, 1, 16'h0064, 8'd4,  8'd3, 1'b1, 8'd0, 0};
    vecs[2] = '{8'h02, 16'h0005, 16'h0000, 1, 16'h0064, 8'd4,  8'd3, 1'b1, 8'd0, 0};
    vecs[3] = '{8'h02, 16'h0700, 16'h0000, 1, 16'h0064, 8'd4,  8'd3, 1'b1, 8'd0, 0};
    vecs[4] = '{8'h7F, 16'h1111, 16'h2222, 3, 16'h0064, 8'd4,  8'd3, 1'b1, 8'd1, 0};
    vecs[5] = '{8'h01, 16'h1234, 16'h0000, 1, 16'h1234, 8'd4,  8'd3, 1'b1, 8'd1, 1};
    vecs[6] = '{8'h01, 16'h1234, 16'h0000, 1, 16'h1234, 8'd4,  8'd3, 1'b1, 8'd1, 1};
    vecs[7] = '{8'h01, 16'h0064, 16'hBEEF, 3, 16'h0064, 8'd4,  8'd3, 1'b1, 8'd1, 1};
    vecs[8] = '{8'h02, 16'h0102, 16'h0908, 2, 16'h0064, 8'd2,  8'd1, 1'b1, 8'd1, 0};
    vecs[9] = '{8'h00, 16'h0000, 16'h0000, 0, 16'h0064, 8'd2,  8'd1, 1'b1, 8'd2, 0};

    u.io_uio    = 1'b0;
    u.io_strobe = 1'b0;
    u.io_din    = 16'h0000;
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
    chk_all("reset", 16'h0000, 8'd16, 8'd9, 1'b0, 8'd0);
    chk("reset.io_dout", u.io_dout, 16'h0000);
    chk("reset.cfg_upd", {15'h0, cfg_upd}, 16'h0000);

    for (int i = 0; i < 10; i++) begin
      upd0 = upd_total;
      xact(vecs[i].cmd, vecs[i].w0, vecs[i].w1, vecs[i].n);
      chk_all($sformatf("vec%0d", i), vecs[i].e_cfg, vecs[i].e_arx, vecs[i].e_ary,
              vecs[i].e_ready, vecs[i].e_err);
      chk($sformatf("vec%0d.upd_cycles", i), 16'(upd_total - upd0), 16'(vecs[i].e_upd));
      chk($sformatf("vec%0d.io_dout", i), u.io_dout, 16'h0000);
    end

    // Readback of status: cfg=0064, arx=2, ary=1, err_cnt=2 at this point.
    @(negedge clk_sys);
    u.io_uio = 1'b1;
    send_word(16'h0003, rb[0]);
    for (int i = 1; i < 5; i++) send_word(16'hCAFE, rb[i]);
    @(negedge clk_sys);
    u.io_uio = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
`ifdef UIO_CFG_READBACK_EN
    rb_exp = '{16'h01A4, 16'h0064, 16'h0102, 16'h0002, 16'h0000};
    e_err  = 8'd2;
`else
    rb_exp = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    e_err  = 8'd3;
`endif
    for (int i = 0; i < 5; i++) chk($sformatf("readback%0d", i), rb[i], rb_exp[i]);
    chk("readback.err_cnt", {8'h00, err_cnt}, {8'h00, e_err});
    chk("readback.idle_dout", u.io_dout, 16'h0000);

    // Strobe held high for 10 cycles: only the first word counts.
    upd0 = upd_total;
    @(negedge clk_sys);
    u.io_uio = 1'b1;
    send_word(16'h0001, d);
    @(negedge clk_sys);
    u.io_din    = 16'h00AA;
    u.io_strobe = 1'b1;
    @(negedge clk_sys);
    u.io_din = 16'h5555;
    repeat (9) @(negedge clk_sys);
    u.io_strobe = 1'b0;
    u.io_uio    = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("held.cfg", cfg, 16'h00AA);
    chk("held.upd_cycles", 16'(upd_total - upd0), 16'd1);

    // io_uio falls together with a strobe edge: the word is dropped.
    upd0 = upd_total;
    @(negedge clk_sys);
    u.io_uio = 1'b1;
    send_word(16'h0001, d);
    @(negedge clk_sys);
    u.io_din    = 16'h7777;
    u.io_strobe = 1'b1;
    u.io_uio    = 1'b0;
    @(negedge clk_sys);
    u.io_strobe = 1'b0;
    repeat (2) @(negedge clk_sys);
    chk("uio_fall.cfg", cfg, 16'h00AA);
    chk("uio_fall.upd_cycles", 16'(upd_total - upd0), 16'd0);

    // Error counter saturates.
    for (int i = 0; i < 300; i++) xact(8'h7F, 16'h0000, 16'h0000, 0);
    chk("sat.err_cnt", {8'h00, err_cnt}, 16'h00FF);

    // Reset asserted mid-command takes effect without a clock edge.
    @(negedge clk_sys);
    u.io_uio = 1'b1;
    send_word(16'h0001, d);
    @(negedge clk_sys);
    u.io_din    = 16'h4321;
    u.io_strobe = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 16'h0000, 8'd16, 8'd9, 1'b0, 8'd0);
    chk("async_rst.io_dout", u.io_dout, 16'h0000);
    chk("async_rst.cfg_upd", {15'h0, cfg_upd}, 16'h0000);
    u.io_uio = 1'b0;
    @(negedge clk_sys);
    reset_n     = 1'b1;
    u.io_strobe = 1'b0;
    repeat (3) @(negedge clk_sys);
    chk_all("post_rst", 16'h0000, 8'd16, 8'd9, 1'b0, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
